// File: rtl/bist_seq_ctrl.sv
// BIST session sequencer: drives LFSR/MISR enables through M_ROUNDS rounds of
// N_PAT patterns, then compares the final MISR signature against GOLDEN.
module bist_seq_ctrl #(
    parameter int                 N_PAT    = 10,
    parameter int                 M_ROUNDS = 9,
    parameter int                 SIG_W    = 16,
    parameter logic [SIG_W-1:0]   GOLDEN   = SIG_W'(16'hA5C3)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             ABORT,
    input  logic [SIG_W-1:0] SIG_IN,
    output logic             LFSR_LOAD,
    output logic             MISR_CLR,
    output logic             LFSR_EN,
    output logic             MISR_EN,
    output logic             OUT,
    output logic             RUNNING,
    output logic             BIST_END,
    output logic             PASS,
    output logic             FAIL,
    output logic             ABORTED
);

    localparam int PW = $clog2(N_PAT + 1);
    localparam int RW = $clog2(M_ROUNDS + 1);
    localparam logic [PW-1:0] PAT_LAST = PW'(N_PAT - 1);
    localparam logic [RW-1:0] RND_LAST = RW'(M_ROUNDS - 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] INIT    = 3'd1;
    localparam logic [2:0] RUN     = 3'd2;
    localparam logic [2:0] GAP     = 3'd3;
    localparam logic [2:0] COMPARE = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] pat_q, pat_d;
    logic [RW-1:0] rnd_q, rnd_d;
    logic          start_d_q;
    logic          pass_q, pass_d;
    logic          fail_q, fail_d;
    logic          abrt_q, abrt_d;
    logic          trig;
    logic          busy;

    assign trig = START & ~start_d_q;
    // ABORT only counts while a session owns the datapath (not in IDLE/DONE).
    assign busy = (state_q == INIT) || (state_q == RUN) ||
                  (state_q == GAP)  || (state_q == COMPARE);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rnd_d   = rnd_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        abrt_d  = abrt_q;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d = INIT;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    abrt_d  = 1'b0;
                end
            end
            INIT: begin
                pat_d   = '0;
                rnd_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                if (pat_q == PAT_LAST) begin
                    pat_d = '0;
                    if (rnd_q == RND_LAST) begin
                        state_d = COMPARE;
                    end else begin
                        rnd_d   = rnd_q + 1'b1;
                        state_d = GAP;
                    end
                end else begin
                    pat_d = pat_q + 1'b1;
                end
            end
            GAP:     state_d = RUN;
            COMPARE: begin
                pass_d  = (SIG_IN == GOLDEN);
                fail_d  = (SIG_IN != GOLDEN);
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (ABORT && busy) begin
            state_d = IDLE;
            pat_d   = '0;
            rnd_d   = '0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            abrt_d  = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            rnd_q     <= '0;
            start_d_q <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= 1'b0;
            abrt_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            rnd_q     <= rnd_d;
            start_d_q <= START;
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            abrt_q    <= abrt_d;
        end
    end

    // Moore decode from registered state only.
    assign LFSR_LOAD = (state_q == INIT);
    assign MISR_CLR  = (state_q == INIT);
    assign LFSR_EN   = (state_q == RUN);
    assign MISR_EN   = (state_q == RUN);
    assign OUT       = (state_q == RUN);
    assign RUNNING   = busy;
    assign BIST_END  = (state_q == DONE);
    assign PASS      = pass_q;
    assign FAIL      = fail_q;
    assign ABORTED   = abrt_q;

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Random + directed bench for bist_seq_ctrl; two instances (default and 1x1)
// are checked every cycle against a session-offset reference model.
module tb_bist_seq_ctrl;

    localparam logic [15:0] GOLD = 16'hA5C3;

    logic        CLK, RESET, START, ABORT;
    logic [15:0] SIG_IN;
    logic        lload[2], mclr[2], len[2], men[2], tout[2];
    logic        run[2], bend[2], pass[2], fail[2], abrt[2];
    logic [9:0]  ov[2];

    int checks = 0;
    int errors = 0;

    bist_seq_ctrl u_dut0 (
        .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT), .SIG_IN(SIG_IN),
        .LFSR_LOAD(lload[0]), .MISR_CLR(mclr[0]), .LFSR_EN(len[0]), .MISR_EN(men[0]),
        .OUT(tout[0]), .RUNNING(run[0]), .BIST_END(bend[0]), .PASS(pass[0]),
        .FAIL(fail[0]), .ABORTED(abrt[0])
    );

    bist_seq_ctrl #(.N_PAT(1), .M_ROUNDS(1)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT), .SIG_IN(SIG_IN),
        .LFSR_LOAD(lload[1]), .MISR_CLR(mclr[1]), .LFSR_EN(len[1]), .MISR_EN(men[1]),
        .OUT(tout[1]), .RUNNING(run[1]), .BIST_END(bend[1]), .PASS(pass[1]),
        .FAIL(fail[1]), .ABORTED(abrt[1])
    );

    for (genvar g = 0; g < 2; g++) begin : g_pack
        assign ov[g] = {lload[g], mclr[g], len[g], men[g], tout[g],
                        run[g], bend[g], pass[g], fail[g], abrt[g]};
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a session is a timeline of offsets k from the trigger edge.
    // k=0 INIT, 1..L patterns and gaps, L+1 COMPARE, L+2 DONE.
    int NP[2] = '{10, 1};
    int MR[2] = '{9, 1};
    int mk[2];
    bit mact[2], mpass[2], mfail[2], mabrt[2], mprev[2];

    function automatic int lastk(input int i);
        return NP[i] * MR[i] + MR[i] - 1;
    endfunction

    function automatic logic [9:0] expv(input int i);
        logic [9:0] v;
        v = {7'b0, mpass[i], mfail[i], mabrt[i]};
        if (mact[i]) begin
            if (mk[i] == 0) begin
                v[9] = 1'b1; v[8] = 1'b1; v[4] = 1'b1;
            end else if (mk[i] <= lastk(i)) begin
                v[4] = 1'b1;
                if ((mk[i] - 1) % (NP[i] + 1) != NP[i]) v[7:5] = 3'b111;
            end else if (mk[i] == lastk(i) + 1) begin
                v[4] = 1'b1;
            end else begin
                v[3] = 1'b1;
            end
        end
        return v;
    endfunction

    always @(posedge CLK or posedge RESET) begin
        for (int i = 0; i < 2; i++) begin
            if (RESET) begin
                mact[i] <= 1'b0; mk[i] <= 0; mprev[i] <= 1'b0;
                mpass[i] <= 1'b0; mfail[i] <= 1'b0; mabrt[i] <= 1'b0;
            end else begin
                if (mact[i]) begin
                    if (ABORT && mk[i] <= lastk(i) + 1) begin
                        mact[i] <= 1'b0; mabrt[i] <= 1'b1;
                        mpass[i] <= 1'b0; mfail[i] <= 1'b0;
                    end else if (mk[i] == lastk(i) + 2) begin
                        mact[i] <= 1'b0;
                    end else begin
                        if (mk[i] == lastk(i) + 1) begin
                            mpass[i] <= (SIG_IN == GOLD);
                            mfail[i] <= (SIG_IN != GOLD);
                        end
                        mk[i] <= mk[i] + 1;
                    end
                end else if (START && !mprev[i]) begin
                    mact[i] <= 1'b1; mk[i] <= 0;
                    mpass[i] <= 1'b0; mfail[i] <= 1'b0; mabrt[i] <= 1'b0;
                end
                mprev[i] <= START;
            end
        end
    end

    bit chk_en = 1'b0;
    bit cnt_en = 1'b0;
    int nlen, nend, nidle_run;

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("out0", 32'(ov[0]), 32'(expv(0)));
            chk("out1", 32'(ov[1]), 32'(expv(1)));
        end
        if (cnt_en) begin
            if (len[0]) nlen++;
            if (bend[0]) nend++;
            if (run[0] && !len[0] && !lload[0]) nidle_run++;
        end
    end

    task automatic trigger();
        @(negedge CLK) START = 1'b0;
        @(negedge CLK) START = 1'b1;
    endtask

    task automatic full_session(input logic [15:0] sig, input string tag);
        SIG_IN = sig;
        trigger();
        nlen = 0; nend = 0; nidle_run = 0; cnt_en = 1'b1;
        repeat (105) @(negedge CLK);
        cnt_en = 1'b0;
        chk({tag, "_lfsr_en"}, 32'(nlen), 32'd90);
        chk({tag, "_bist_end"}, 32'(nend), 32'd1);
        chk({tag, "_gap_cmp"}, 32'(nidle_run), 32'd9);
        chk({tag, "_flags"}, 32'({pass[0], fail[0], abrt[0]}),
            (sig == GOLD) ? 32'b100 : 32'b010);
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; ABORT = 1'b0; SIG_IN = GOLD;
        #2;
        chk("rst_out0", 32'(ov[0]), 32'd0);
        chk("rst_out1", 32'(ov[1]), 32'd0);
        chk_en = 1'b1;
        @(negedge CLK) RESET = 1'b0;

        full_session(GOLD, "pass");
        full_session(GOLD ^ 16'h0001, "fail");

        // abort mid-run, then a fresh session clears ABORTED
        SIG_IN = GOLD;
        trigger();
        for (int t = 0; t < 200 && !(mact[0] && mk[0] == 50); t++) @(negedge CLK);
        chk("abort_reach", 32'(mk[0]), 32'd50);
        ABORT = 1'b1;
        @(negedge CLK) ABORT = 1'b0;
        chk("abort_state", 32'({run[0], bend[0], abrt[0]}), 32'b001);
        repeat (3) @(negedge CLK);
        full_session(GOLD, "after_abort");

        // START held high, with a re-pulse during RUN
        trigger();
        nend = 0; cnt_en = 1'b1;
        repeat (40) @(negedge CLK);
        START = 1'b0;
        @(negedge CLK) START = 1'b1;
        repeat (260) @(negedge CLK);
        cnt_en = 1'b0;
        chk("hold_one_end", 32'(nend), 32'd1);

        // 1x1 instance: INIT, RUN, COMPARE, DONE
        SIG_IN = GOLD;
        repeat (3) @(negedge CLK);
        trigger();
        @(negedge CLK) chk("small_init", 32'(ov[1]), 32'b11_0001_0000);
        @(negedge CLK) chk("small_run",  32'(ov[1]), 32'b00_1111_0000);
        @(negedge CLK) chk("small_cmp",  32'(ov[1]), 32'b00_0001_0000);
        @(negedge CLK) chk("small_done", 32'(ov[1]), 32'b00_0000_1100);
        @(negedge CLK) chk("small_idle", 32'(ov[1]), 32'b00_0000_0100);

        // asynchronous reset between edges mid-run
        repeat (100) @(negedge CLK);
        trigger();
        repeat (30) @(negedge CLK);
        #3 RESET = 1'b1;
        #1;
        chk("rst_async0", 32'(ov[0]), 32'd0);
        chk("rst_async1", 32'(ov[1]), 32'd0);
        @(negedge CLK) RESET = 1'b0;
        START = 1'b0;
        full_session(GOLD, "after_rst");

        // random phase
        for (int c = 0; c < 3000; c++) begin
            @(negedge CLK);
            if ($urandom_range(19) == 0) START = ~START;
            ABORT  = ($urandom_range(63) == 0);
            SIG_IN = $urandom_range(1) ? GOLD : 16'($urandom);
            RESET  = ($urandom_range(799) == 0);
        end
        @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
